dc_rep_fifo: RTL and testbench

//  Flit buffer directly downstream of the data-cache reply upload serializer. It accepts 16-bit

---
 rtl/dc_rep_fifo.sv | 69 ++++++
 tb/tb_dc_rep_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dc_rep_fifo.sv
// Reply flit buffer between the data-cache reply serializer and the ring-side arbiter.
// Show-ahead FIFO; rdy and valid are decoded only from the registered occupancy count.
module dc_rep_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       dc_flit_in,
  input  logic              v_dc_flit_in,
  output logic              rep_fifo_rdy,
  output logic [15:0]       rep_flit_out,
  output logic              v_rep_flit_out,
  input  logic              rep_flit_ack,
  output logic [ADDR_W:0]   rep_fifo_cnt,
  output logic              rep_fifo_ovf
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf;
  logic              push;
  logic              pop;

  // Flags come from the registered count, so an ack never opens rdy in the same cycle.
  assign rep_fifo_rdy   = (cnt != FULL_CNT);
  assign v_rep_flit_out = (cnt != '0);
  assign push           = v_dc_flit_in & rep_fifo_rdy;
  assign pop            = rep_flit_ack & v_rep_flit_out;
  assign rep_flit_out   = v_rep_flit_out ? mem[rd_ptr] : 16'h0000;
  assign rep_fifo_cnt   = cnt;
  assign rep_fifo_ovf   = ovf;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dc_flit_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      if (v_dc_flit_in && !rep_fifo_rdy) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dc_rep_fifo.sv
// Self-checking bench for dc_rep_fifo: directed boundary scenarios plus a random
// phase, all compared every cycle against a queue-based model of the FIFO.
module tb_dc_rep_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic [15:0]       dc_flit_in;
  logic              v_dc_flit_in;
  logic              rep_fifo_rdy;
  logic [15:0]       rep_flit_out;
  logic              v_rep_flit_out;
  logic              rep_flit_ack;
  logic [ADDR_W:0]   rep_fifo_cnt;
  logic              rep_fifo_ovf;

  int checks;
  int failures;

  logic [15:0] model_q [$];
  bit          model_ovf;
  bit          model_valid;

  dc_rep_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .dc_flit_in     (dc_flit_in),
    .v_dc_flit_in   (v_dc_flit_in),
    .rep_fifo_rdy   (rep_fifo_rdy),
    .rep_flit_out   (rep_flit_out),
    .v_rep_flit_out (v_rep_flit_out),
    .rep_flit_ack   (rep_flit_ack),
    .rep_fifo_cnt   (rep_fifo_cnt),
    .rep_fifo_ovf   (rep_fifo_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output with the model's view of the FIFO.
  task automatic compareAll();
    int n;
    n = model_q.size();
    checkOutput("cnt",   32'(rep_fifo_cnt),   32'(n));
    checkOutput("rdy",   32'(rep_fifo_rdy),   32'(n != DEPTH));
    checkOutput("v_out", 32'(v_rep_flit_out), 32'(n != 0));
    checkOutput("head",  32'(rep_flit_out),   (n != 0) ? 32'(model_q[0]) : 32'h0);
    checkOutput("ovf",   32'(rep_fifo_ovf),   32'(model_ovf));
  endtask

  // One cycle: check the state left by the previous edge, drive new inputs, advance the model.
  task automatic applyStimulus(input bit r, input bit vin, input logic [15:0] data, input bit ack);
    int n;
    bit do_push;
    bit do_pop;
    @(negedge clk);
    if (model_valid) compareAll();
    rst          = r;
    v_dc_flit_in = vin;
    dc_flit_in   = data;
    rep_flit_ack = ack;
    if (r) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      n       = model_q.size();
      do_push = vin && (n != DEPTH);
      do_pop  = ack && (n != 0);
      if (vin && n == DEPTH) model_ovf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(data);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compareAll();
    rst          = 1'b0;
    v_dc_flit_in = 1'b0;
    rep_flit_ack = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    model_valid  = 1'b0;
    model_ovf    = 1'b0;
    rst          = 1'b1;
    v_dc_flit_in = 1'b0;
    dc_flit_in   = 16'h0;
    rep_flit_ack = 1'b0;

    // Reset then idle
    applyStimulus(1, 0, 16'h0, 0);
    applyStimulus(1, 0, 16'h0, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 0);
    settle();
    checkOutput("reset_cnt", 32'(rep_fifo_cnt), 32'd0);
    checkOutput("reset_rdy", 32'(rep_fifo_rdy), 32'd1);
    checkOutput("reset_flit", 32'(rep_flit_out), 32'h0);

    // One 11-flit reply, then drain in order
    for (int i = 0; i < 11; i++) applyStimulus(0, 1, 16'hA000 + 16'(i), 0);
    settle();
    checkOutput("reply_cnt", 32'(rep_fifo_cnt), 32'd11);
    checkOutput("reply_head", 32'(rep_flit_out), 32'hA000);
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 16'h0, 1);
    settle();
    checkOutput("drain_cnt", 32'(rep_fifo_cnt), 32'd0);

    // Fill to full, then a push while full is dropped and flags overflow
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 16'hC000 + 16'(i), 0);
    settle();
    checkOutput("full_cnt", 32'(rep_fifo_cnt), 32'd16);
    checkOutput("full_rdy", 32'(rep_fifo_rdy), 32'd0);
    applyStimulus(0, 1, 16'hBEEF, 0);
    settle();
    checkOutput("ovf_set", 32'(rep_fifo_ovf), 32'd1);
    checkOutput("ovf_cnt", 32'(rep_fifo_cnt), 32'd16);

    // Full with push and ack together: only the pop is taken
    applyStimulus(0, 1, 16'hDEAD, 1);
    settle();
    checkOutput("fullpp_cnt", 32'(rep_fifo_cnt), 32'd15);
    checkOutput("fullpp_rdy", 32'(rep_fifo_rdy), 32'd1);
    checkOutput("ovf_sticky", 32'(rep_fifo_ovf), 32'd1);

    // Steady stream at cnt=5 with wrapping pointers
    applyStimulus(1, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 16'h5000 + 16'(i), 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, 16'h5100 + 16'(i), 1);
    settle();
    checkOutput("stream_cnt", 32'(rep_fifo_cnt), 32'd5);
    checkOutput("stream_head", 32'(rep_flit_out), 32'h5100 + 32'd35);

    // Reset mid-stream with cnt=7 while push and ack are active
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 16'h7000 + 16'(i), 0);
    applyStimulus(0, 1, 16'h7777, 1);
    applyStimulus(1, 1, 16'h7778, 1);
    settle();
    checkOutput("midrst_cnt", 32'(rep_fifo_cnt), 32'd0);
    checkOutput("midrst_v", 32'(v_rep_flit_out), 32'd0);
    checkOutput("midrst_rdy", 32'(rep_fifo_rdy), 32'd1);
    checkOutput("midrst_ovf", 32'(rep_fifo_ovf), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'h7900 + 16'(i), 1);

    // Random traffic with shifting push/ack biases and rare resets
    for (int phase = 0; phase < 4; phase++) begin
      int push_bias;
      int ack_bias;
      push_bias = (phase == 0) ? 80 : (phase == 1) ? 30 : (phase == 2) ? 95 : 60;
      ack_bias  = (phase == 0) ? 30 : (phase == 1) ? 80 : (phase == 2) ? 20 : 60;
      for (int i = 0; i < 500; i++) begin
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < push_bias,
                      16'($urandom),
                      $urandom_range(0, 99) < ack_bias);
      end
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
